alarm_scheduler: RTL
====================

ALARM_SCHEDULER -- requirements
Module: alarm_scheduler

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 4: number of alarm slots (2..8).
REQ-002 SHALL have parameter RING_TICKS, default 15: clk_ac cycles per ring burst.
REQ-003 SHALL have parameter SNOOZE_MIN, default 5: snooze length in minutes (1..59).
REQ-004 SHALL have port clk_ac  in  1: clock for all logic, ~2.98 Hz divided tick.
REQ-005 SHALL have port reset  in  1: synchronous, active-high.
REQ-006 SHALL have port clock_inp  in  18: current time {hour[17:12], min[11:6], sec[5:0]}, binary.
REQ-007 SHALL have port wr_en  in  1: slot write strobe.
REQ-008 SHALL have port wr_slot  in  $clog2(NUM_SLOTS): slot index to write.
REQ-009 SHALL have port wr_time  in  18: alarm time, same format as clock_inp.
REQ-010 SHALL have port wr_arm  in  1: armed flag written with wr_time.
REQ-011 SHALL have port dismiss  in  1: stop current alarm, level sampled per cycle.
REQ-012 SHALL have port snooze  in  1: defer current alarm by SNOOZE_MIN.
REQ-013 SHALL have port ot_ac  out  1: ring output to LED/buzzer.
REQ-014 SHALL have port active_slot  out  $clog2(NUM_SLOTS): slot owning the ring FSM.
REQ-015 SHALL have port busy  out  1: FSM not IDLE.
REQ-016 SHALL have port pending  out  NUM_SLOTS: per-slot queued-trigger bits.

Function
REQ-017 SHALL register clock_inp into time_q each cycle; new_sec = (clock_inp != time_q).
REQ-018 SHALL compare all armed slots in parallel; on new_sec, each armed slot whose time equals clock_inp SHALL set its pending bit.
REQ-019 SHALL, in IDLE with any pending bit set, grant the lowest-index pending slot: next cycle state=RING, active_slot=index, that pending bit cleared.
REQ-020 SHALL drive ot_ac=1 exactly while state=RING; ring counter loads RING_TICKS-1 on entry and decrements per cycle.
REQ-021 SHALL return RING->IDLE when counter reaches 0 with no dismiss/snooze (auto-off; RING lasts exactly RING_TICKS cycles).
REQ-022 SHALL return RING->IDLE on the cycle after dismiss=1; ot_ac=0 that next cycle.
REQ-023 SHALL, on snooze=1 in RING, go to SNOOZE and store snooze_time = clock_inp + SNOOZE_MIN minutes, seconds kept, minute wrap mod 60 with hour carry, hour wrap mod 24.
REQ-024 SHALL leave SNOOZE for RING (counter reloaded) on new_sec with clock_inp == snooze_time; dismiss in SNOOZE SHALL go to IDLE.
REQ-025 SHALL give dismiss priority over snooze when both are 1 in the same cycle.
REQ-026 SHALL keep pending bits set while busy; they are serviced in index order after return to IDLE.
REQ-027 SHALL drop a write whose hour>23, min>59 or sec>59 (slot unchanged).
REQ-028 SHALL apply a valid write next cycle; a write with wr_arm=0 SHALL clear that slot's pending bit, overriding a same-cycle set.
REQ-029 SHALL let a write to active_slot leave the running RING/SNOOZE unaffected.

Reset
REQ-030 SHALL on reset: state=IDLE, ot_ac=0, busy=0, active_slot=0, pending=0, all slots disarmed with time 0, counter 0, time_q=clock_inp (no new_sec first cycle after reset).
REQ-031 SHALL abort RING/SNOOZE immediately when reset asserts mid-operation.

Configuration
REQ-032 SHALL compile SNOOZE state, snooze_time register and adder only when ALARM_SNOOZE_EN is defined.
REQ-033 SHALL, without ALARM_SNOOZE_EN, ignore snooze input; RING exits only by dismiss, timeout or reset.

Structure
REQ-034 SHALL place the 18-bit time struct typedef, FSM state enum (IDLE, RING, SNOOZE), field limits (23/59) and the add-minutes function in shared package alarm_pkg.
REQ-035 SHALL implement slot registers, write validation and parallel compare in sub-module alarm_slot_bank, exporting a per-slot match vector.

Verification
REQ-036 SHALL cover: slot0=07:30:00 armed, clock steps 07:29:59->07:30:00 -> pending[0]=1, next cycle ot_ac=1 for exactly 15 cycles then IDLE.
REQ-037 SHALL cover: slots 1 and 2 both 12:00:00 -> slot1 rings first, pending[2] held, slot2 rings right after slot1 ends.
REQ-038 SHALL cover: ring at 23:58:10, snooze=1 -> SNOOZE, ot_ac=0; ring resumes when clock reaches 00:03:10.
REQ-039 SHALL cover: dismiss and snooze both 1 during RING -> IDLE, no snooze_time effect.
REQ-040 SHALL cover: write 24:00:00 to slot3 -> dropped; write wr_arm=0 to slot with pending set -> pending cleared, never rings.
REQ-041 SHALL cover: reset during RING at tick 5 -> ot_ac=0, pending=0, busy=0 next cycle.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types for the alarm scheduler: time struct, FSM states, field limits
// and minute arithmetic used by the snooze path.
package alarm_pkg;

  typedef struct packed {
    logic [5:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
  } alarm_time_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } state_t;

  localparam logic [5:0] HOUR_MAX   = 6'd23;
  localparam logic [5:0] MINSEC_MAX = 6'd59;

  function automatic logic time_valid(alarm_time_t t);
    return (t.hour <= HOUR_MAX) && (t.min <= MINSEC_MAX) && (t.sec <= MINSEC_MAX);
  endfunction

  // Seconds are kept; minutes wrap mod 60 carrying into hours, hours wrap mod 24.
  function automatic alarm_time_t add_minutes(alarm_time_t t, logic [5:0] mins);
    alarm_time_t r;
    logic [6:0]  msum;
    r    = t;
    msum = {1'b0, t.min} + {1'b0, mins};
    if (msum > {1'b0, MINSEC_MAX}) begin
      r.min  = 6'(msum - 7'd60);
      r.hour = (t.hour >= HOUR_MAX) ? 6'd0 : t.hour + 6'd1;
    end else begin
      r.min = msum[5:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/alarm_slot_bank.sv
// Alarm slot registers: validated writes and parallel compare of every armed
// slot against the current time.
module alarm_slot_bank
  import alarm_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int SW        = $clog2(NUM_SLOTS)
) (
  input  logic                 clk_ac,
  input  logic                 reset,
  input  alarm_time_t          clock_inp,
  input  logic                 wr_en,
  input  logic [SW-1:0]        wr_slot,
  input  alarm_time_t          wr_time,
  input  logic                 wr_arm,
  output logic [NUM_SLOTS-1:0] match,
  output logic [NUM_SLOTS-1:0] disarm
);

  logic wr_ok;
  assign wr_ok = wr_en && time_valid(wr_time);

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    alarm_time_t slot_time;
    logic        slot_arm;
    logic        sel;

    assign sel = wr_ok && (wr_slot == SW'(i));

    always_ff @(posedge clk_ac) begin
      if (reset) begin
        slot_time <= '0;
        slot_arm  <= 1'b0;
      end else if (sel) begin
        slot_time <= wr_time;
        slot_arm  <= wr_arm;
      end
    end

    assign match[i]  = slot_arm && (slot_time == clock_inp);
    // A disarming write also kills any queued trigger for the slot.
    assign disarm[i] = sel && !wr_arm;
  end

endmodule

// File: rtl/alarm_scheduler.sv
// Multi-slot alarm scheduler: queues slot triggers and runs one ring FSM.
// Snooze support is compiled in only when ALARM_SNOOZE_EN is defined.
module alarm_scheduler
  import alarm_pkg::*;
#(
  parameter int NUM_SLOTS  = 4,
  parameter int RING_TICKS = 15,
  parameter int SNOOZE_MIN = 5
) (
  input  logic                         clk_ac,
  input  logic                         reset,
  input  logic [17:0]                  clock_inp,
  input  logic                         wr_en,
  input  logic [$clog2(NUM_SLOTS)-1:0] wr_slot,
  input  logic [17:0]                  wr_time,
  input  logic                         wr_arm,
  input  logic                         dismiss,
  input  logic                         snooze,
  output logic                         ot_ac,
  output logic [$clog2(NUM_SLOTS)-1:0] active_slot,
  output logic                         busy,
  output logic [NUM_SLOTS-1:0]         pending
);

  localparam int SW = $clog2(NUM_SLOTS);
  localparam int CW = $clog2(RING_TICKS + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(RING_TICKS - 1);

  state_t               state;
  alarm_time_t          now, time_q;
  logic                 new_sec;
  logic [CW-1:0]        ring_cnt;
  logic [NUM_SLOTS-1:0] match, disarm, grant_mask, pending_nxt;
  logic [SW-1:0]        grant_idx;
  logic                 grant;

  assign now     = clock_inp;
  assign new_sec = (now != time_q);

  alarm_slot_bank #(.NUM_SLOTS(NUM_SLOTS), .SW(SW)) u_bank (
    .clk_ac    (clk_ac),
    .reset     (reset),
    .clock_inp (now),
    .wr_en     (wr_en),
    .wr_slot   (wr_slot),
    .wr_time   (wr_time),
    .wr_arm    (wr_arm),
    .match     (match),
    .disarm    (disarm)
  );

  always_comb begin
    grant_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--)
      if (pending[i]) grant_idx = SW'(i);
  end

  assign grant      = (state == IDLE) && (|pending);
  assign grant_mask = grant ? (NUM_SLOTS'(1) << grant_idx) : '0;
  // Disarm wins over a same-cycle trigger; triggers while busy stay queued.
  assign pending_nxt = ((pending & ~grant_mask) | (match & {NUM_SLOTS{new_sec}})) & ~disarm;

`ifdef ALARM_SNOOZE_EN
  alarm_time_t snooze_time, snooze_at;
  assign snooze_at = add_minutes(now, 6'(SNOOZE_MIN));
`else
  logic snooze_unused;
  assign snooze_unused = snooze;
`endif

  always_ff @(posedge clk_ac) begin
    if (reset) begin
      state       <= IDLE;
      ot_ac       <= 1'b0;
      busy        <= 1'b0;
      active_slot <= '0;
      pending     <= '0;
      ring_cnt    <= '0;
      time_q      <= now;
`ifdef ALARM_SNOOZE_EN
      snooze_time <= '0;
`endif
    end else begin
      time_q  <= now;
      pending <= pending_nxt;
      case (state)
        IDLE: begin
          if (grant) begin
            state       <= RING;
            ot_ac       <= 1'b1;
            busy        <= 1'b1;
            active_slot <= grant_idx;
            ring_cnt    <= CNT_LOAD;
          end
        end
        RING: begin
          if (dismiss) begin
            state <= IDLE;
            ot_ac <= 1'b0;
            busy  <= 1'b0;
          end
`ifdef ALARM_SNOOZE_EN
          else if (snooze) begin
            state       <= SNOOZE;
            ot_ac       <= 1'b0;
            snooze_time <= snooze_at;
          end
`endif
          else if (ring_cnt == '0) begin
            state <= IDLE;
            ot_ac <= 1'b0;
            busy  <= 1'b0;
          end else begin
            ring_cnt <= ring_cnt - 1'b1;
          end
        end
`ifdef ALARM_SNOOZE_EN
        SNOOZE: begin
          if (dismiss) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (new_sec && (now == snooze_time)) begin
            state    <= RING;
            ot_ac    <= 1'b1;
            ring_cnt <= CNT_LOAD;
          end
        end
`endif
        default: begin
          state <= IDLE;
          ot_ac <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
